// File: rtl/interrupt_request_controller.sv
// Initiator side of the interrupt handshake: synchronises and edge-detects IRQ lines,
// masks and prioritises them, and runs the request/acknowledge/return protocol.
module interrupt_request_controller #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic               CLK,
  input  logic               CLR_n,
  input  logic [NUM_IRQ-1:0] IrqLines,
  input  logic               MaskWrite,
  input  logic [NUM_IRQ-1:0] MaskData,
  input  logic               EPCWrite,
  input  logic               ReturnFromInt,
  output logic               InterruptIn,
  output logic               InterruptHandler,
  output logic [2:0]         IrqId,
  output logic [15:0]        HandlerAddr,
  output logic [NUM_IRQ-1:0] Pending,
  output logic [NUM_IRQ-1:0] IrqMask
);

  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

  state_t             state, state_next;
  logic [NUM_IRQ-1:0] s1, s2, s3;
  logic [NUM_IRQ-1:0] rise, active, clr, pending_next;
  logic [2:0]         win_id, id_next;
  logic [15:0]        win_addr, addr_next;
  logic               irq_in_next, handler_next;

  assign rise   = s2 & ~s3;
  assign active = Pending & IrqMask;

  // Lowest enabled pending index wins, so scan from the top down and let later hits override.
  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) win_id = 3'(i);
    end
  end

  // Vector arithmetic is deliberately 16-bit so the address wraps modulo 2^16.
  assign win_addr = VEC_BASE + VEC_STRIDE * {13'd0, win_id};

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next   = state;
    irq_in_next  = InterruptIn;
    handler_next = InterruptHandler;
    id_next      = IrqId;
    addr_next    = HandlerAddr;
    clr          = '0;
    case (state)
      IDLE: begin
        if (|active) begin
          state_next  = REQUEST;
          irq_in_next = 1'b1;
          id_next     = win_id;
          addr_next   = win_addr;
        end
      end
      REQUEST: begin
        if (EPCWrite) begin
          state_next   = SERVICE;
          irq_in_next  = 1'b0;
          handler_next = 1'b1;
          for (int i = 0; i < NUM_IRQ; i++) clr[i] = (IrqId == 3'(i));
        end
      end
      SERVICE: begin
        if (ReturnFromInt) begin
          state_next   = IDLE;
          handler_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    // A fresh edge on the bit being acknowledged must not be lost.
    pending_next = (Pending & ~clr) | rise;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state            <= IDLE;
      s1               <= '0;
      s2               <= '0;
      s3               <= '0;
      Pending          <= '0;
      IrqMask          <= '1;
      InterruptIn      <= 1'b0;
      InterruptHandler <= 1'b0;
      IrqId            <= '0;
      HandlerAddr      <= VEC_BASE;
    end else begin
      state            <= state_next;
      s1               <= IrqLines;
      s2               <= s1;
      s3               <= s2;
      Pending          <= pending_next;
      InterruptIn      <= irq_in_next;
      InterruptHandler <= handler_next;
      IrqId            <= id_next;
      HandlerAddr      <= addr_next;
      if (MaskWrite) IrqMask <= MaskData;
    end
  end

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Directed bench for interrupt_request_controller: reset, latency, priority, mask,
// nesting block and spurious-handshake cases with hand-computed expectations.
module tb_interrupt_request_controller;

  logic        CLK = 1'b0;
  logic        CLR_n;
  logic [3:0]  IrqLines;
  logic        MaskWrite;
  logic [3:0]  MaskData;
  logic        EPCWrite;
  logic        ReturnFromInt;
  logic        InterruptIn;
  logic        InterruptHandler;
  logic [2:0]  IrqId;
  logic [15:0] HandlerAddr;
  logic [3:0]  Pending;
  logic [3:0]  IrqMask;

  int checks   = 0;
  int failures = 0;

  interrupt_request_controller dut (
    .CLK              (CLK),
    .CLR_n            (CLR_n),
    .IrqLines         (IrqLines),
    .MaskWrite        (MaskWrite),
    .MaskData         (MaskData),
    .EPCWrite         (EPCWrite),
    .ReturnFromInt    (ReturnFromInt),
    .InterruptIn      (InterruptIn),
    .InterruptHandler (InterruptHandler),
    .IrqId            (IrqId),
    .HandlerAddr      (HandlerAddr),
    .Pending          (Pending),
    .IrqMask          (IrqMask)
  );

  always #5 CLK = ~CLK;

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    CLR_n = 1'b0; IrqLines = '0; MaskWrite = 1'b0; MaskData = '0;
    EPCWrite = 1'b0; ReturnFromInt = 1'b0;
    tick(3);
    check("rst_int_in",  16'(InterruptIn),      16'h0);
    check("rst_handler", 16'(InterruptHandler), 16'h0);
    check("rst_id",      16'(IrqId),            16'h0);
    check("rst_addr",    HandlerAddr,           16'h0040);
    check("rst_pending", 16'(Pending),          16'h0);
    check("rst_mask",    16'(IrqMask),          16'hf);
    CLR_n = 1'b1;
    tick(2);

    // Single IRQ 2: pending at the third edge, request after the fourth.
    IrqLines = 4'b0100;
    tick(2);
    check("t2_pend_early", 16'(Pending), 16'h0);
    tick(1);
    check("t2_pend_set",   16'(Pending), 16'h4);
    check("t2_int_early",  16'(InterruptIn), 16'h0);
    tick(1);
    check("t2_int_in",     16'(InterruptIn), 16'h1);
    check("t2_id",         16'(IrqId), 16'h2);
    check("t2_addr",       HandlerAddr, 16'h0060);
    tick(1);
    check("t2_int_held",   16'(InterruptIn), 16'h1);
    EPCWrite = 1'b1;
    tick(1);
    EPCWrite = 1'b0;
    check("t2_ack_int",     16'(InterruptIn), 16'h0);
    check("t2_ack_handler", 16'(InterruptHandler), 16'h1);
    check("t2_ack_pending", 16'(Pending), 16'h0);
    ReturnFromInt = 1'b1;
    tick(1);
    ReturnFromInt = 1'b0;
    check("t2_rfi_handler", 16'(InterruptHandler), 16'h0);
    IrqLines = '0;
    tick(1);
    check("t2_idle_quiet", 16'(InterruptIn), 16'h0);
    tick(3);

    // Priority: IRQ1 and IRQ3 together, IRQ1 first.
    IrqLines = 4'b1010;
    tick(3);
    check("t3_pending", 16'(Pending), 16'ha);
    tick(1);
    check("t3_int_in", 16'(InterruptIn), 16'h1);
    check("t3_id1",    16'(IrqId), 16'h1);
    check("t3_addr1",  HandlerAddr, 16'h0050);
    EPCWrite = 1'b1;
    tick(1);
    EPCWrite = 1'b0;
    check("t3_ack_pending", 16'(Pending), 16'h8);
    tick(2);
    check("t3_no_nest", 16'(InterruptIn), 16'h0);
    ReturnFromInt = 1'b1;
    tick(1);
    ReturnFromInt = 1'b0;
    check("t3_rfi_int", 16'(InterruptIn), 16'h0);
    tick(1);
    check("t3_int_in3", 16'(InterruptIn), 16'h1);
    check("t3_id3",     16'(IrqId), 16'h3);
    check("t3_addr3",   HandlerAddr, 16'h0070);
    EPCWrite = 1'b1;
    tick(1);
    EPCWrite = 1'b0;
    ReturnFromInt = 1'b1;
    tick(1);
    ReturnFromInt = 1'b0;
    IrqLines = '0;
    tick(4);

    // Mask: IRQ0 masked stays pending; unmask releases it one cycle later.
    MaskWrite = 1'b1; MaskData = 4'b1110;
    tick(1);
    MaskWrite = 1'b0;
    check("t4_mask", 16'(IrqMask), 16'he);
    IrqLines = 4'b0001;
    tick(5);
    check("t4_pend_masked", 16'(Pending), 16'h1);
    check("t4_no_req",      16'(InterruptIn), 16'h0);
    MaskWrite = 1'b1; MaskData = 4'b1111;
    tick(1);
    MaskWrite = 1'b0;
    check("t4_unmask_same", 16'(InterruptIn), 16'h0);
    tick(1);
    check("t4_unmask_req",  16'(InterruptIn), 16'h1);
    check("t4_id0",         16'(IrqId), 16'h0);
    check("t4_addr0",       HandlerAddr, 16'h0040);
    MaskWrite = 1'b1; MaskData = 4'b0000;
    tick(1);
    MaskWrite = 1'b0;
    check("t4_req_kept", 16'(InterruptIn), 16'h1);
    EPCWrite = 1'b1;
    tick(1);
    EPCWrite = 1'b0;
    check("t4_ack_handler", 16'(InterruptHandler), 16'h1);
    check("t4_ack_pending", 16'(Pending), 16'h0);
    MaskWrite = 1'b1; MaskData = 4'b1111;
    tick(1);
    MaskWrite = 1'b0;
    ReturnFromInt = 1'b1;
    tick(1);
    ReturnFromInt = 1'b0;

    // Nesting block: IRQ1 arrives while IRQ2 is in service.
    IrqLines = 4'b0100;
    tick(4);
    check("t5_id2", 16'(IrqId), 16'h2);
    EPCWrite = 1'b1;
    tick(1);
    EPCWrite = 1'b0;
    IrqLines = 4'b0110;
    tick(4);
    check("t5_pend1",   16'(Pending), 16'h2);
    check("t5_no_req",  16'(InterruptIn), 16'h0);
    check("t5_in_serv", 16'(InterruptHandler), 16'h1);
    ReturnFromInt = 1'b1;
    tick(1);
    ReturnFromInt = 1'b0;
    tick(1);
    check("t5_req1",  16'(InterruptIn), 16'h1);
    check("t5_id1",   16'(IrqId), 16'h1);
    check("t5_addr1", HandlerAddr, 16'h0050);

    // Spurious: ReturnFromInt in REQUEST, both strobes in REQUEST, EPCWrite in IDLE.
    ReturnFromInt = 1'b1;
    tick(1);
    ReturnFromInt = 1'b0;
    check("t6_rfi_req_int", 16'(InterruptIn), 16'h1);
    check("t6_rfi_req_hnd", 16'(InterruptHandler), 16'h0);
    check("t6_rfi_req_pnd", 16'(Pending), 16'h2);
    EPCWrite = 1'b1; ReturnFromInt = 1'b1;
    tick(1);
    EPCWrite = 1'b0; ReturnFromInt = 1'b0;
    check("t6_both_hnd", 16'(InterruptHandler), 16'h1);
    check("t6_both_int", 16'(InterruptIn), 16'h0);
    check("t6_both_pnd", 16'(Pending), 16'h0);
    tick(1);
    check("t6_still_serv", 16'(InterruptHandler), 16'h1);
    ReturnFromInt = 1'b1;
    tick(1);
    ReturnFromInt = 1'b0;
    IrqLines = '0;
    tick(4);
    MaskWrite = 1'b1; MaskData = 4'b1110;
    tick(1);
    MaskWrite = 1'b0;
    IrqLines = 4'b0001;
    tick(3);
    EPCWrite = 1'b1;
    tick(2);
    EPCWrite = 1'b0;
    check("t6_epc_idle_pnd", 16'(Pending), 16'h1);
    check("t6_epc_idle_int", 16'(InterruptIn), 16'h0);
    check("t6_epc_idle_hnd", 16'(InterruptHandler), 16'h0);

    // Reset mid-REQUEST clears everything without waiting for a clock edge.
    MaskWrite = 1'b1; MaskData = 4'b1111;
    tick(1);
    MaskWrite = 1'b0;
    tick(1);
    check("t1_pre_req", 16'(InterruptIn), 16'h1);
    CLR_n = 1'b0;
    #1;
    check("t1_rst_int",  16'(InterruptIn), 16'h0);
    check("t1_rst_pnd",  16'(Pending), 16'h0);
    check("t1_rst_mask", 16'(IrqMask), 16'hf);
    check("t1_rst_addr", HandlerAddr, 16'h0040);
    check("t1_rst_id",   16'(IrqId), 16'h0);
    CLR_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
